// File: rtl/ahb_apb_pkg.sv
// ahb_apb_pkg
//   Shared types for the AHB-lite to APB front end.
//   htrans_e      : AHB transfer type encoding.
//   HRESP_*       : AHB response encoding.
//   front_state_e : states of the front-end sequencer.
package ahb_apb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WDATA = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_ERR1  = 3'd4,
        ST_ERR2  = 3'd5
    } front_state_e;

endpackage

// File: rtl/apb_wdog.sv
// apb_wdog
//   Counts the cycles an APB command has been outstanding and flags the last
//   allowed cycle so the front end can abandon the access with an AHB ERROR.
// Ports
//   clk     : clock
//   rst_n   : asynchronous active-low reset
//   clear   : hold the count at zero (no command outstanding)
//   enable  : command outstanding this cycle
//   expired : this is the TIMEOUT-th outstanding cycle and no completion is allowed after it
module apb_wdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_r;

    // Outstanding-cycle counter; saturates on the final cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable && (count_r != LAST_CNT)) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    // The count is zero in the first outstanding cycle, so LAST_CNT marks cycle TIMEOUT
    assign expired = enable & (count_r == LAST_CNT);

endmodule

// File: rtl/ahb_apb_front.sv
// ahb_apb_front
//   AHB-lite slave that turns each single NONSEQ/SEQ transfer into one command
//   for the APB master stage, stalling the AHB bus until that stage reports
//   completion. Out-of-range addresses and APB timeouts give a two-cycle ERROR.
// Ports
//   pclk, preset            : clock, asynchronous active-low reset
//   hsel, htrans, hwrite,
//   haddr, hwdata, hready_in: AHB-lite slave inputs
//   hreadyout, hresp, hrdata: AHB-lite slave outputs (all registered)
//   transfer, read_write,
//   apb_write_paddr,
//   apb_write_data,
//   apb_read_paddr          : command to the APB stage, held stable until apb_done
//   apb_read_data_out       : read data from the APB stage
//   apb_done                : one-cycle completion pulse from the APB stage
module ahb_apb_front
    import ahb_apb_pkg::*;
#(
    parameter int HADDR_W = 32,
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic               pclk,
    input  logic               preset,
    input  logic               hsel,
    input  logic [1:0]         htrans,
    input  logic               hwrite,
    input  logic [HADDR_W-1:0] haddr,
    input  logic [DATA_W-1:0]  hwdata,
    input  logic               hready_in,
    output logic               hreadyout,
    output logic               hresp,
    output logic [DATA_W-1:0]  hrdata,
    output logic               transfer,
    output logic               read_write,
    output logic [ADDR_W-1:0]  apb_write_paddr,
    output logic [DATA_W-1:0]  apb_write_data,
    output logic [ADDR_W-1:0]  apb_read_paddr,
    input  logic [DATA_W-1:0]  apb_read_data_out,
    input  logic               apb_done
);

    front_state_e state_r;

    logic accept_s;
    logic addr_ok_s;
    logic busy_s;
    logic wdog_expired_s;

    // A new address phase is taken only when this slave is ready, which
    // includes the ERR2 cycle and the OKAY cycle that completes a transfer.
    assign accept_s  = hsel & hready_in & hreadyout
                     & ((htrans == HTRANS_NONSEQ) | (htrans == HTRANS_SEQ))
                     & ((state_r == ST_IDLE) | (state_r == ST_ERR2));
    assign addr_ok_s = (haddr[HADDR_W-1:ADDR_W] == {(HADDR_W-ADDR_W){1'b0}});
    assign busy_s    = (state_r == ST_ISSUE) | (state_r == ST_WAIT);

    apb_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (pclk),
        .rst_n   (preset),
        .clear   (~busy_s),
        .enable  (busy_s),
        .expired (wdog_expired_s)
    );

    // Front-end sequencer: AHB handshake, APB command registers, read-data return
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            state_r         <= ST_IDLE;
            hreadyout       <= 1'b1;
            hresp           <= HRESP_OKAY;
            hrdata          <= {DATA_W{1'b0}};
            transfer        <= 1'b0;
            read_write      <= 1'b0;
            apb_write_paddr <= {ADDR_W{1'b0}};
            apb_write_data  <= {DATA_W{1'b0}};
            apb_read_paddr  <= {ADDR_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE, ST_ERR2: begin
                    hreadyout <= 1'b1;
                    hresp     <= HRESP_OKAY;
                    state_r   <= ST_IDLE;
                    if (accept_s) begin
                        hreadyout <= 1'b0;
                        if (!addr_ok_s) begin
                            hresp   <= HRESP_ERROR;
                            state_r <= ST_ERR1;
                        end else if (hwrite) begin
                            // Address latches only move for the direction in use
                            read_write      <= 1'b0;
                            apb_write_paddr <= haddr[ADDR_W-1:0];
                            state_r         <= ST_WDATA;
                        end else begin
                            read_write     <= 1'b1;
                            apb_read_paddr <= haddr[ADDR_W-1:0];
                            transfer       <= 1'b1;
                            state_r        <= ST_ISSUE;
                        end
                    end
                end
                ST_WDATA: begin
                    // hwdata is valid in this data-phase cycle
                    apb_write_data <= hwdata;
                    transfer       <= 1'b1;
                    state_r        <= ST_ISSUE;
                end
                ST_ISSUE, ST_WAIT: begin
                    // Completion pulses during ISSUE belong to no command of ours
                    if ((state_r == ST_WAIT) && apb_done) begin
                        transfer  <= 1'b0;
                        hreadyout <= 1'b1;
                        hresp     <= HRESP_OKAY;
                        if (read_write) begin
                            hrdata <= apb_read_data_out;
                        end else begin
                            hrdata <= hrdata;
                        end
                        state_r <= ST_IDLE;
                    end else if (wdog_expired_s) begin
                        transfer <= 1'b0;
                        hresp    <= HRESP_ERROR;
                        state_r  <= ST_ERR1;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_ERR1: begin
                    hreadyout <= 1'b1;
                    hresp     <= HRESP_ERROR;
                    state_r   <= ST_ERR2;
                end
                default: begin
                    hreadyout <= 1'b1;
                    hresp     <= HRESP_OKAY;
                    transfer  <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_apb_front.sv
// tb_ahb_apb_front
//   Directed bench for ahb_apb_front. The bench keeps a transaction-level view
//   of the bus (expected handshake per cycle, an APB-side memory, the last
//   command issued) and compares every DUT output against it once per cycle.
module tb_ahb_apb_front;
    import ahb_apb_pkg::*;

    localparam int HADDR_W = 32;
    localparam int ADDR_W  = 9;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 64;

    logic               pclk = 1'b0;
    logic               preset;
    logic               hsel;
    logic [1:0]         htrans;
    logic               hwrite;
    logic [HADDR_W-1:0] haddr;
    logic [DATA_W-1:0]  hwdata;
    logic               hready_in;
    logic               hreadyout;
    logic               hresp;
    logic [DATA_W-1:0]  hrdata;
    logic               transfer;
    logic               read_write;
    logic [ADDR_W-1:0]  apb_write_paddr;
    logic [DATA_W-1:0]  apb_write_data;
    logic [ADDR_W-1:0]  apb_read_paddr;
    logic [DATA_W-1:0]  apb_read_data_out;
    logic               apb_done;

    always #5 pclk = ~pclk;

    ahb_apb_front #(
        .HADDR_W (HADDR_W),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .pclk              (pclk),
        .preset            (preset),
        .hsel              (hsel),
        .htrans            (htrans),
        .hwrite            (hwrite),
        .haddr             (haddr),
        .hwdata            (hwdata),
        .hready_in         (hready_in),
        .hreadyout         (hreadyout),
        .hresp             (hresp),
        .hrdata            (hrdata),
        .transfer          (transfer),
        .read_write        (read_write),
        .apb_write_paddr   (apb_write_paddr),
        .apb_write_data    (apb_write_data),
        .apb_read_paddr    (apb_read_paddr),
        .apb_read_data_out (apb_read_data_out),
        .apb_done          (apb_done)
    );

    // Model: APB-side memory and the outputs expected in the current cycle
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic              e_hready, e_hresp, e_transfer, e_rw;
    logic [DATA_W-1:0] e_hrdata, e_wdata;
    logic [ADDR_W-1:0] e_wpaddr, e_rpaddr;

    int vectors     = 0;
    int miscompares = 0;
    int lo_cnt      = 0;
    int xfer_cnt    = 0;
    int lo_base;
    int xfer_base;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model
    task automatic compare_cycle();
        check("hreadyout", 32'(hreadyout), 32'(e_hready));
        check("hresp", 32'(hresp), 32'(e_hresp));
        check("transfer", 32'(transfer), 32'(e_transfer));
        check("hrdata", 32'(hrdata), 32'(e_hrdata));
        if (e_transfer || !preset) begin
            check("read_write", 32'(read_write), 32'(e_rw));
            check("apb_write_paddr", 32'(apb_write_paddr), 32'(e_wpaddr));
            check("apb_write_data", 32'(apb_write_data), 32'(e_wdata));
            check("apb_read_paddr", 32'(apb_read_paddr), 32'(e_rpaddr));
        end
        if (hreadyout == 1'b0) lo_cnt++;
        if (transfer == 1'b1) xfer_cnt++;
    endtask

    task automatic tick();
        @(negedge pclk);
        compare_cycle();
        @(posedge pclk);
        #1;
    endtask

    task automatic drive_idle();
        hsel      = 1'b0;
        htrans    = HTRANS_IDLE;
        hwrite    = 1'b0;
        haddr     = 32'h0000_0000;
        hready_in = 1'b1;
        apb_done  = 1'b0;
    endtask

    task automatic idle_exp();
        e_hready   = 1'b1;
        e_hresp    = 1'b0;
        e_transfer = 1'b0;
    endtask

    // A cycle in which no transfer may start
    task automatic idle_cycle(input logic sel, input logic [1:0] trans, input logic rdy, input logic done);
        hsel      = sel;
        htrans    = trans;
        hready_in = rdy;
        hwrite    = 1'b1;
        haddr     = 32'h0000_0003;
        apb_done  = done;
        tick();
        drive_idle();
        idle_exp();
    endtask

    task automatic addr_phase(input logic wr, input logic [HADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
        hsel   = 1'b1;
        htrans = HTRANS_NONSEQ;
        hwrite = wr;
        haddr  = a;
        hwdata = ~wd;
        tick();
        drive_idle();
    endtask

    task automatic err_seq();
        e_hready = 1'b0; e_hresp = 1'b1; e_transfer = 1'b0;
        tick();
        e_hready = 1'b1; e_hresp = 1'b1;
    endtask

    // APB command outstanding: done_at = index of the WAIT cycle carrying
    // apb_done; a negative value pulses apb_done in ISSUE only (never completes).
    task automatic apb_phase(input logic is_read, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d, input int done_at);
        e_hready = 1'b0; e_hresp = 1'b0; e_transfer = 1'b1; e_rw = is_read;
        if (is_read) e_rpaddr = a;
        else begin
            e_wpaddr = a;
            e_wdata  = d;
        end
        for (int tc = 1; tc <= TIMEOUT; tc++) begin
            apb_done          = ((tc >= 2) && (tc - 2 == done_at)) || ((tc == 1) && (done_at < 0));
            apb_read_data_out = ((tc >= 2) && (tc - 2 == done_at)) ? mem[a] : 8'hEE;
            tick();
            apb_done          = 1'b0;
            apb_read_data_out = 8'hEE;
            if ((tc >= 2) && (tc - 2 == done_at)) begin
                idle_exp();
                if (is_read) e_hrdata = mem[a];
                else mem[a] = d;
                return;
            end
        end
        err_seq();
    endtask

    task automatic read_txn(input logic [HADDR_W-1:0] a, input int done_at);
        addr_phase(1'b0, a, 8'h00);
        if (a[HADDR_W-1:ADDR_W] != '0) err_seq();
        else apb_phase(1'b1, a[ADDR_W-1:0], 8'h00, done_at);
    endtask

    task automatic write_txn(input logic [HADDR_W-1:0] a, input logic [DATA_W-1:0] d, input int done_at);
        addr_phase(1'b1, a, d);
        hwdata = d;
        if (a[HADDR_W-1:ADDR_W] != '0) begin
            err_seq();
        end else begin
            e_hready = 1'b0; e_hresp = 1'b0; e_transfer = 1'b0;
            tick();
            hwdata = ~d;
            apb_phase(1'b0, a[ADDR_W-1:0], d, done_at);
        end
    endtask

    task automatic mark();
        lo_base   = lo_cnt;
        xfer_base = xfer_cnt;
    endtask

    task automatic reset_exp();
        idle_exp();
        e_rw = 1'b0; e_hrdata = 8'h00; e_wdata = 8'h00; e_wpaddr = 9'h000; e_rpaddr = 9'h000;
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'h00;
        mem[9'h105] = 8'h3C;
        drive_idle();
        hwdata            = 8'h00;
        apb_read_data_out = 8'hEE;
        reset_exp();
        preset = 1'b1;
        #2;
        preset = 1'b0;
        #1;
        check("reset_hreadyout", 32'(hreadyout), 32'h1);
        check("reset_hresp", 32'(hresp), 32'h0);
        check("reset_transfer", 32'(transfer), 32'h0);
        tick();
        tick();
        preset = 1'b1;
        idle_cycle(1'b0, HTRANS_IDLE, 1'b1, 1'b0);

        // Write 0x005 <= 0xA5, apb_done two cycles after ISSUE
        mark();
        write_txn(32'h0000_0005, 8'hA5, 1);
        check("wr_transfer_cycles", 32'(xfer_cnt - xfer_base), 32'd3);
        check("wr_paddr", 32'(apb_write_paddr), 32'h005);
        check("wr_data", 32'(apb_write_data), 32'hA5);
        idle_cycle(1'b0, HTRANS_IDLE, 1'b1, 1'b0);

        // Read 0x105 returning 0x3C, apb_done in the first WAIT cycle
        mark();
        read_txn(32'h0000_0105, 0);
        check("rd_cycles_to_data", 32'(lo_cnt - lo_base + 1), 32'd3);
        check("rd_hrdata", 32'(hrdata), 32'h3C);
        check("rd_paddr", 32'(apb_read_paddr), 32'h105);
        check("rd_keeps_wr_paddr", 32'(apb_write_paddr), 32'h005);

        // Write directly after the read completion; hrdata must not move
        mark();
        write_txn(32'h0000_0002, 8'h77, 0);
        check("wr_cycles_to_done", 32'(lo_cnt - lo_base + 1), 32'd4);
        check("wr_keeps_hrdata", 32'(hrdata), 32'h3C);

        // Out-of-range read and write: ERROR and no APB command
        mark();
        read_txn(32'h0000_0200, 0);
        write_txn(32'h8000_0005, 8'hCC, 0);
        check("bad_addr_no_transfer", 32'(xfer_cnt - xfer_base), 32'd0);

        // Back-to-back from ERR2: write 0x001 <= 0x11 then read 0x001
        mark();
        write_txn(32'h0000_0001, 8'h11, 0);
        read_txn(32'h0000_0001, 0);
        check("b2b_hrdata", 32'(hrdata), 32'h11);
        check("b2b_transfer_cycles", 32'(xfer_cnt - xfer_base), 32'd4);

        // Non-starting cycles: BUSY, IDLE, deselected, bus not ready, stray done
        mark();
        idle_cycle(1'b1, HTRANS_BUSY, 1'b1, 1'b0);
        idle_cycle(1'b1, HTRANS_IDLE, 1'b1, 1'b0);
        idle_cycle(1'b0, HTRANS_NONSEQ, 1'b1, 1'b0);
        idle_cycle(1'b1, HTRANS_SEQ, 1'b0, 1'b0);
        idle_cycle(1'b0, HTRANS_IDLE, 1'b1, 1'b1);
        check("idle_no_transfer", 32'(xfer_cnt - xfer_base), 32'd0);
        check("idle_no_wait", 32'(lo_cnt - lo_base), 32'd0);

        // Read that never completes: watchdog ends it with ERROR
        mark();
        read_txn(32'h0000_0003, -1);
        check("timeout_transfer_cycles", 32'(xfer_cnt - xfer_base), 32'd64);
        idle_cycle(1'b0, HTRANS_IDLE, 1'b1, 1'b0);

        // Reset in the middle of an outstanding read
        addr_phase(1'b0, 32'h0000_00FF, 8'h00);
        e_hready = 1'b0; e_hresp = 1'b0; e_transfer = 1'b1; e_rw = 1'b1; e_rpaddr = 9'h0FF;
        tick();
        preset = 1'b0;
        #1;
        check("midrst_transfer", 32'(transfer), 32'h0);
        check("midrst_hreadyout", 32'(hreadyout), 32'h1);
        check("midrst_hrdata", 32'(hrdata), 32'h00);
        reset_exp();
        tick();
        preset = 1'b1;
        idle_cycle(1'b0, HTRANS_IDLE, 1'b1, 1'b0);
        read_txn(32'h0000_0105, 2);
        check("post_reset_hrdata", 32'(hrdata), 32'h3C);
        idle_cycle(1'b0, HTRANS_IDLE, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
